rv_stream_rr_arbiter: RTL and testbench
=======================================

Name: rv_stream_rr_arbiter

Overview:
N-to-1 round-robin stream arbiter with packet locking. It shares one downstream stream port between NUM_REQS requester streams and is the inverse-direction companion of the stream demux. The chosen beat is registered through a 2-entry skid stage, so ready_in never depends combinationally on ready_out. Typical use: merging per-warp or per-bank request streams into a single shared memory or pipeline port.

Parameters:
NUM_REQS, 4, number of requester streams (>=1; any value, not only powers of two).
DATAW, 8, payload width per beat.
LOG_NUM_REQS, (NUM_REQS>1 ? clog2(NUM_REQS) : 1), width of requester index.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
valid_in  input  NUM_REQS  per-requester beat valid.
data_in  input  NUM_REQS*DATAW  per-requester payload; requester i at bits [(i+1)*DATAW-1 : i*DATAW].
last_in  input  NUM_REQS  per-requester end-of-packet flag, qualified by valid_in.
ready_in  output  NUM_REQS  per-requester accept; at most one bit high per cycle.
valid_out  output  1  downstream beat valid.
data_out  output  DATAW  downstream payload.
last_out  output  1  end-of-packet flag for the downstream beat.
sel_out  output  LOG_NUM_REQS  index of the requester that sourced the downstream beat.
ready_out  input  1  downstream accept.

Behaviour:
- Reset (reset=0, asynchronous): valid_out=0, data_out=0, last_out=0, sel_out=0, rr_ptr=0, locked=0, lock_idx=0, skid stage empty. All ready_in=0 while reset is asserted.
- Handshake: a beat transfers when valid && ready are both high at a clk edge. Requesters hold valid_in/data_in/last_in until accepted. data_out/last_out/sel_out stay stable while valid_out=1 and ready_out=0.
- Arbitration, unlocked: grant g = first i with valid_in[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQS (wrap to 0 after NUM_REQS-1, including non-power-of-two counts).
- Arbitration, locked: the only candidate is lock_idx. Other requesters' valid_in is ignored. If valid_in[lock_idx]=0, no grant is made and the cycle is a bubble.
- ready_in[g] = 1 iff the skid entry is empty (registered). All other ready_in = 0. No grant means all ready_in = 0.
- On an accepted beat from g:
  - last_in[g]=0: locked<=1, lock_idx<=g, rr_ptr unchanged.
  - last_in[g]=1: locked<=0, rr_ptr <= (g+1) mod NUM_REQS.
- Output stage: main register plus one skid entry.
  - Latency: beat accepted at edge N appears on valid_out after edge N.
  - Throughput: 1 beat/cycle while ready_out=1.
  - On ready_out=0 with the main register full, one further beat is captured into the skid entry, then ready_in drops.
  - When ready_out returns, the skid entry moves to the main register in order. No loss, no duplication.
- Simultaneous events: a downstream pop and an upstream push in the same cycle are both honoured. The grant pointer update and the accept happen on the same edge.
- NUM_REQS=1: sel_out is constantly 0, and locking is still tracked but has no effect on grant choice.
- Reset mid-packet: lock is cleared and buffered beats are discarded. After release, arbitration restarts from requester 0.

Test Plan:
1. NUM_REQS=4; all valid_in=1111, last_in=1111, ready_out=1, data_in[i]=0x10+i -> sel_out sequence 0,1,2,3,0,… one per cycle; first valid_out one cycle after the first accept; data_out=0x10,0x11,0x12,0x13.
2. Locking: req1 sends a 3-beat packet (last on beat 3) while req0 and req2 stay valid with single beats -> sel_out 1,1,1,2,0, and last_out=1 on the third beat only.
3. Backpressure: continuous stream from req0, ready_out=0 for 5 cycles -> exactly 2 beats buffered, ready_in[0]=0 after that, data_out stable; on ready_out=1 the beats emerge in order with no loss or duplication.
4. Wrap with NUM_REQS=3: rr_ptr=2 with req2 and req0 valid -> grant 2, then 0; sel_out never reaches 3.
5. Locked bubble: req3 mid-packet drops valid for 2 cycles while req0 is valid -> ready_in=0000 for 2 cycles; req3 resumes and completes before req0 is granted.
6. Asynchronous reset: pull reset low between clk edges mid-packet with valid_out=1 -> valid_out=0 immediately; after release with req2 and req0 valid, the first grant is req0.

Source files
------------

// File: rtl/rv_stream_rr_arbiter.sv
// N-to-1 round-robin stream arbiter with packet locking.
// The granted beat lands in a main register backed by one skid entry, so ready_in never depends on ready_out.
module rv_stream_rr_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int DATAW        = 8,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  input  logic [NUM_REQS-1:0]       last_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic                      last_out,
  output logic [LOG_NUM_REQS-1:0]   sel_out,
  input  logic                      ready_out
);

  typedef logic [LOG_NUM_REQS-1:0] idx_t;

  idx_t             rr_ptr;
  idx_t             lock_idx;
  logic             locked;

  logic             skid_valid;
  logic [DATAW-1:0] skid_data;
  logic             skid_last;
  idx_t             skid_sel;

  logic             gnt_valid;
  idx_t             gnt_idx;
  logic [DATAW-1:0] gnt_data;
  logic             gnt_last;
  logic             push;
  logic             pop;

  // (base + ofs) mod NUM_REQS for ofs < NUM_REQS; works for non-power-of-two counts.
  function automatic idx_t rot_idx(input idx_t base, input int ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= NUM_REQS) sum = sum - NUM_REQS;
    return idx_t'(sum);
  endfunction

  // Scanning from the far end lets the candidate closest to rr_ptr overwrite the others.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (locked) begin
      gnt_valid = valid_in[lock_idx];
      gnt_idx   = lock_idx;
    end else begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        if (valid_in[rot_idx(rr_ptr, k)]) begin
          gnt_valid = 1'b1;
          gnt_idx   = rot_idx(rr_ptr, k);
        end
      end
    end
  end

  assign gnt_data = data_in[int'(gnt_idx)*DATAW +: DATAW];
  assign gnt_last = last_in[gnt_idx];

  assign push = gnt_valid & ~skid_valid;
  assign pop  = valid_out & ready_out;

  always_comb begin
    ready_in = '0;
    if (gnt_valid && !skid_valid && reset) ready_in[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (push) begin
      if (gnt_last) begin
        locked <= 1'b0;
        rr_ptr <= rot_idx(gnt_idx, 1);
      end else begin
        locked   <= 1'b1;
        lock_idx <= gnt_idx;
      end
    end
  end

  // The skid entry only fills while the main register is held, so it always drains first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      last_out   <= 1'b0;
      sel_out    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_sel   <= '0;
    end else if (pop || !valid_out) begin
      if (skid_valid) begin
        valid_out  <= 1'b1;
        data_out   <= skid_data;
        last_out   <= skid_last;
        sel_out    <= skid_sel;
        skid_valid <= 1'b0;
      end else if (push) begin
        valid_out <= 1'b1;
        data_out  <= gnt_data;
        last_out  <= gnt_last;
        sel_out   <= gnt_idx;
      end else begin
        valid_out <= 1'b0;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= gnt_data;
      skid_last  <= gnt_last;
      skid_sel   <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_rv_stream_rr_arbiter.sv
// Bench for rv_stream_rr_arbiter: vector table, directed corner sequences and a random run against a queue model.
module tb_rv_stream_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  valid_in, last_in, ready_in;
  logic [7:0]  req_data [4];
  logic [31:0] data_in;
  logic        valid_out, last_out, ready_out;
  logic [7:0]  data_out;
  logic [1:0]  sel_out;

  logic [2:0]  valid_in3, last_in3, ready_in3;
  logic [23:0] data_in3;
  logic        valid_out3, last_out3, ready_out3;
  logic [7:0]  data_out3;
  logic [1:0]  sel_out3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb data_in = {req_data[3], req_data[2], req_data[1], req_data[0]};
  assign data_in3 = 24'h222120;

  rv_stream_rr_arbiter #(.NUM_REQS(4), .DATAW(8)) u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out), .last_out(last_out),
    .sel_out(sel_out), .ready_out(ready_out)
  );

  rv_stream_rr_arbiter #(.NUM_REQS(3), .DATAW(8)) u_dut3 (
    .clk(clk), .reset(reset), .valid_in(valid_in3), .data_in(data_in3), .last_in(last_in3),
    .ready_in(ready_in3), .valid_out(valid_out3), .data_out(data_out3), .last_out(last_out3),
    .sel_out(sel_out3), .ready_out(ready_out3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    valid_in  = '0;
    last_in   = '0;
    valid_in3 = '0;
    last_in3  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] v;
    logic [3:0] l;
    logic       ro;
    logic [3:0] e_rdy;
    logic       e_vo;
    logic [1:0] e_sel;
    logic [7:0] e_data;
    logic       e_last;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, logic [3:0] v, logic [3:0] l, logic [3:0] e_rdy,
                              logic e_vo, logic [1:0] e_sel, logic e_last);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.ro = 1'b1;
    r.e_rdy = e_rdy; r.e_vo = e_vo; r.e_sel = e_sel; r.e_last = e_last;
    r.e_data = 8'h10 + 8'(e_sel);
    return r;
  endfunction

  // Reference model state for the random run.
  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [1:0] s;
  } beat_t;

  beat_t m_q[$];
  int    m_rr;
  int    m_lock_idx;
  bit    m_locked;

  function automatic int model_grant(logic [3:0] v);
    if (m_locked) return v[m_lock_idx] ? m_lock_idx : -1;
    for (int k = 0; k < 4; k++)
      if (v[(m_rr + k) % 4]) return (m_rr + k) % 4;
    return -1;
  endfunction

  initial begin
    logic        r0;
    int          acc, pops, g;
    logic [7:0]  nxt;
    logic [3:0]  exp_rdy, obs_rdy;
    bit          do_pop;
    beat_t       nb;

    reset = 1'b1; valid_in = '0; last_in = '0; ready_out = 1'b1;
    valid_in3 = '0; last_in3 = '0; ready_out3 = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i] = 8'h10 + 8'(i);
    #1 reset = 1'b0;
    valid_in = 4'hF; last_in = 4'hF;
    #11;
    chk("reset ready_in", 32'(ready_in), 32'h0);
    chk("reset valid_out", 32'(valid_out), 32'h0);
    chk("reset data_out", 32'(data_out), 32'h0);
    chk("reset last_out", 32'(last_out), 32'h0);
    chk("reset sel_out", 32'(sel_out), 32'h0);

    // Rotation, packet locking, and a locked bubble.
    tbl.push_back(mk(1, 4'hF, 4'hF, 4'h1, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'h2, 1, 0, 1));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'h4, 1, 1, 1));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'h8, 1, 2, 1));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'h1, 1, 3, 1));
    tbl.push_back(mk(0, 4'hF, 4'hF, 4'h2, 1, 0, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 1, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h2, 4'h0, 4'h2, 0, 0, 0));
    tbl.push_back(mk(0, 4'h7, 4'h5, 4'h2, 1, 1, 0));
    tbl.push_back(mk(0, 4'h7, 4'h7, 4'h2, 1, 1, 0));
    tbl.push_back(mk(0, 4'h5, 4'h5, 4'h4, 1, 1, 1));
    tbl.push_back(mk(0, 4'h1, 4'h1, 4'h1, 1, 2, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 0, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h8, 4'h0, 4'h8, 0, 0, 0));
    tbl.push_back(mk(0, 4'h1, 4'h1, 4'h0, 1, 3, 0));
    tbl.push_back(mk(0, 4'h1, 4'h1, 4'h0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h9, 4'h9, 4'h8, 0, 0, 0));
    tbl.push_back(mk(0, 4'h1, 4'h1, 4'h1, 1, 3, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 0, 1));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 0, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) apply_reset();
      valid_in = tbl[i].v; last_in = tbl[i].l; ready_out = tbl[i].ro;
      @(negedge clk);
      chk($sformatf("row%0d ready_in", i), 32'(ready_in), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d valid_out", i), 32'(valid_out), 32'(tbl[i].e_vo));
      if (tbl[i].e_vo)
        chk($sformatf("row%0d sel/data/last", i), {15'd0, sel_out, data_out, 6'd0, last_out},
            {15'd0, tbl[i].e_sel, tbl[i].e_data, 6'd0, tbl[i].e_last});
      @(posedge clk); #1;
    end

    // Backpressure: two beats buffered, then in-order drain at full rate.
    apply_reset();
    ready_out = 1'b0; req_data[0] = 8'hA0; valid_in = 4'b0001; last_in = 4'b0001;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) chk("bp ready_in low", 32'(ready_in), 32'h0);
      if (c >= 1) chk("bp data_out hold", {23'd0, valid_out, data_out}, {23'd0, 1'b1, 8'hA0});
      r0 = ready_in[0];
      @(posedge clk); #1;
      if (r0) begin acc++; req_data[0] = 8'(8'hA0 + acc); end
    end
    chk("bp buffered", 32'(acc), 32'd2);
    ready_out = 1'b1; nxt = 8'hA0; pops = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (valid_out) begin
        chk("bp order", 32'(data_out), 32'(nxt));
        nxt++; pops++;
      end
      r0 = ready_in[0];
      @(posedge clk); #1;
      if (r0) begin acc++; req_data[0] = 8'(8'hA0 + acc); end
    end
    chk("bp drained", 32'(pops), 32'd6);
    for (int i = 0; i < 4; i++) req_data[i] = 8'h10 + 8'(i);

    // Pointer wrap with three requesters.
    apply_reset();
    valid_in3 = 3'b010; last_in3 = 3'b111;
    @(negedge clk); chk("wrap ready c0", 32'(ready_in3), 32'h2);
    @(posedge clk); #1 valid_in3 = 3'b101;
    @(negedge clk); chk("wrap ready c1", 32'(ready_in3), 32'h4);
    chk("wrap out c1", {22'd0, valid_out3, sel_out3, data_out3}, {22'd0, 1'b1, 2'd1, 8'h21});
    @(posedge clk); #1 valid_in3 = 3'b001;
    @(negedge clk); chk("wrap ready c2", 32'(ready_in3), 32'h1);
    chk("wrap out c2", {22'd0, valid_out3, sel_out3, data_out3}, {22'd0, 1'b1, 2'd2, 8'h22});
    @(posedge clk); #1 valid_in3 = 3'b000;
    @(negedge clk);
    chk("wrap out c3", {22'd0, valid_out3, sel_out3, data_out3}, {22'd0, 1'b1, 2'd0, 8'h20});
    @(posedge clk); #1;
    @(negedge clk); chk("wrap drained", 32'(valid_out3), 32'h0);

    // Asynchronous reset mid-packet.
    apply_reset();
    ready_out = 1'b1; valid_in = 4'b0100; last_in = 4'b0000;
    @(negedge clk); chk("areset grant c0", 32'(ready_in), 32'h4);
    @(posedge clk); #1;
    @(negedge clk); chk("areset pre out", {30'd0, valid_out, 1'b0} | 32'(sel_out), 32'h2 | 32'h2);
    #2 reset = 1'b0; valid_in = 4'b0101; last_in = 4'b0101;
    #1;
    chk("areset valid_out", 32'(valid_out), 32'h0);
    chk("areset ready_in", 32'(ready_in), 32'h0);
    chk("areset outputs", {22'd0, sel_out, data_out}, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); chk("areset first grant", 32'(ready_in), 32'h1);
    @(posedge clk); #1 valid_in = 4'b0100;
    @(negedge clk);
    chk("areset second grant", 32'(ready_in), 32'h4);
    chk("areset out", {29'd0, valid_out, sel_out}, {29'd0, 1'b1, 2'd0});
    @(posedge clk); #1;

    // Random traffic against the queue model.
    apply_reset();
    m_q.delete(); m_rr = 0; m_lock_idx = 0; m_locked = 0;
    ready_out = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      g = model_grant(valid_in);
      exp_rdy = (g >= 0 && m_q.size() < 2) ? 4'(1 << g) : 4'h0;
      chk("rnd ready_in", 32'(ready_in), 32'(exp_rdy));
      chk("rnd valid_out", 32'(valid_out), 32'(m_q.size() > 0));
      if (m_q.size() > 0 && valid_out)
        chk("rnd beat", {21'd0, data_out, last_out, sel_out}, {21'd0, m_q[0]});
      obs_rdy = ready_in;
      do_pop  = (m_q.size() > 0) && ready_out;
      if (g >= 0) begin
        nb.d = req_data[g]; nb.l = last_in[g]; nb.s = 2'(g);
      end else nb = '0;
      @(posedge clk); #1;
      if (do_pop) void'(m_q.pop_front());
      if (exp_rdy != 0) begin
        m_q.push_back(nb);
        if (nb.l) begin m_locked = 0; m_rr = (g + 1) % 4; end
        else begin m_locked = 1; m_lock_idx = g; end
      end
      for (int i = 0; i < 4; i++) begin
        if (valid_in[i] && obs_rdy[i]) valid_in[i] = 1'b0;
        if (!valid_in[i] && ($urandom % 3 == 0)) begin
          valid_in[i] = 1'b1;
          last_in[i]  = ($urandom % 3 == 0);
          req_data[i] = 8'($urandom);
        end
      end
      ready_out = ($urandom % 4 != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
